// File: rtl/mcp_data_capture.sv
// ============================================================================
// mcp_data_capture
// ----------------------------------------------------------------------------
// Receive-side capture stage of a multi-cycle-path clock-domain crossing.
//
// The sender holds its data bus quasi-static and flips a request toggle. That
// toggle reaches this domain through a 1-bit synchronizer (sync_toggle). Every
// observed toggle edge is one request. On a request the source bus is sampled
// into a 2-entry FIFO. The FIFO feeds a registered valid/ready output port.
// An acknowledge toggle goes back to the sender. It flips either when a word
// is captured or when a word leaves the FIFO, depending on ACK_ON_CAPTURE.
//
// Parameters
//   BUS_WIDTH       width of the captured data bus
//   ACK_ON_CAPTURE  1: ack flips on capture, 0: ack flips on downstream pop
//
// Ports
//   clk            in   destination-domain clock
//   reset          in   asynchronous, active-high reset
//   sync_toggle    in   synchronized request toggle
//   async_data     in   source bus, stable while a request is outstanding
//   out_ready      in   downstream accepts out_data this cycle
//   clear_overrun  in   synchronous clear of the sticky overrun flag
//   out_valid      out  buffer non-empty, out_data valid
//   out_data       out  head-of-buffer word
//   capture_pulse  out  one-cycle pulse: a word was written on the last edge
//   ack_toggle     out  acknowledge toggle to the sender domain
//   overrun        out  sticky: a request hit a full buffer and was dropped
//
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
// ============================================================================
module mcp_data_capture #(
    parameter int BUS_WIDTH      = 8,
    parameter bit ACK_ON_CAPTURE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_toggle,
    input  logic [BUS_WIDTH-1:0] async_data,
    input  logic                 out_ready,
    input  logic                 clear_overrun,
    output logic                 out_valid,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 capture_pulse,
    output logic                 ack_toggle,
    output logic                 overrun
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 toggle_q;
    logic [BUS_WIDTH-1:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 out_valid_q;
    logic [BUS_WIDTH-1:0] out_data_q;
    logic                 capture_pulse_q;
    logic                 ack_toggle_q;
    logic                 overrun_q;

    logic [BUS_WIDTH-1:0] mem_d [2];
    logic                 wr_ptr_d;
    logic                 rd_ptr_d;
    logic [1:0]           count_d;
    logic                 out_valid_d;
    logic [BUS_WIDTH-1:0] out_data_d;
    logic                 ack_toggle_d;
    logic                 overrun_d;

    // Per-cycle events
    logic req_s;
    logic pop_s;
    logic full_s;
    logic push_s;
    logic drop_s;
    logic ack_flip_s;

    // Request detection, FIFO handshake and overrun classification
    always_comb begin
        req_s  = sync_toggle ^ toggle_q;
        pop_s  = out_valid_q & out_ready;
        full_s = (count_q == 2'd2);
        // A full buffer can still take a word when its head leaves on the
        // same edge: the freed slot is exactly the one the write pointer
        // is aiming at.
        push_s = req_s & (~full_s | pop_s);
        drop_s = req_s & full_s & ~pop_s;
        if (ACK_ON_CAPTURE) begin
            ack_flip_s = push_s;
        end else begin
            ack_flip_s = pop_s;
        end
    end

    // Next-state for storage, pointers, occupancy and the output port
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = async_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        out_valid_d = (count_d != 2'd0);
        // The head word is read from the post-update storage. A word pushed
        // into an empty buffer therefore appears on the very next cycle.
        // A stalled head never moves, because it is neither popped nor
        // overwritten.
        out_data_d  = mem_d[rd_ptr_d];

        ack_toggle_d = ack_toggle_q ^ ack_flip_s;

        // A new overrun takes priority over a simultaneous clear
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers; async reset flushes the buffer and any word in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_q        <= 1'b0;
            mem_q[0]        <= '0;
            mem_q[1]        <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            capture_pulse_q <= 1'b0;
            ack_toggle_q    <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            toggle_q        <= sync_toggle;
            mem_q[0]        <= mem_d[0];
            mem_q[1]        <= mem_d[1];
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            capture_pulse_q <= push_s;
            ack_toggle_q    <= ack_toggle_d;
            overrun_q       <= overrun_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign capture_pulse = capture_pulse_q;
    assign ack_toggle    = ack_toggle_q;
    assign overrun       = overrun_q;

endmodule
